bit_pack_ctrl: RTL and testbench
================================

BIT_PACK_CTRL -- requirements
Module: bit_pack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of code input and packed output word.
REQ-002 SHALL have parameter LEN_WIDTH, default 6: width of code length input, covering 0..DATA_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  code present on in_data/in_len.
REQ-006 in_ready  output  1  block accepts code this cycle.
REQ-007 in_data  input  DATA_WIDTH  code bits, LSB-aligned.
REQ-008 in_len  input  LEN_WIDTH  number of valid code bits.
REQ-009 flush  input  1  single-cycle request to drain partial word.
REQ-010 out_valid  output  1  packed word available.
REQ-011 out_ready  input  1  downstream accepts word.
REQ-012 out_data  output  DATA_WIDTH  packed word, first code in LSBs.
REQ-013 out_last  output  1  word is final word of a flush.
REQ-014 out_bits  output  LEN_WIDTH+1  valid bits in out_data (DATA_WIDTH for full words).
REQ-015 flush_done  output  1  one-cycle pulse when flush completes.

Function
REQ-016 SHALL hold a 2*DATA_WIDTH accumulator acc and bit count cnt (0..2*DATA_WIDTH-1).
REQ-017 SHALL implement FSM states ACC, FLUSH, DONE.
REQ-018 in_ready SHALL be 1 only in ACC with cnt < DATA_WIDTH and flush low.
REQ-019 On accept: acc |= (in_data masked to in_len bits) << cnt; cnt += in_len; bits of in_data above in_len ignored.
REQ-020 in_len > DATA_WIDTH SHALL be treated as DATA_WIDTH; in_len = 0 accepted with no state change.
REQ-021 out_valid SHALL be registered and asserted when cnt >= DATA_WIDTH, one cycle after the filling accept; out_data = acc[DATA_WIDTH-1:0], out_bits = DATA_WIDTH, out_last = 0.
REQ-022 On out_valid && out_ready: acc >>= DATA_WIDTH, cnt -= DATA_WIDTH; out_data/out_bits SHALL hold stable while out_valid && !out_ready.
REQ-023 Accept and emit SHALL never occur in the same cycle (in_ready implies cnt < DATA_WIDTH).
REQ-024 flush in ACC SHALL move to FLUSH; flush has priority over in_valid that cycle; flush outside ACC ignored.
REQ-025 In FLUSH: full words (cnt >= DATA_WIDTH) emitted first as in REQ-021; then if 0 < cnt < DATA_WIDTH emit acc low bits with upper bits zero, out_bits = cnt, out_last = 1.
REQ-026 After final handshake, or immediately if cnt = 0 with no word pending, SHALL enter DONE, pulse flush_done one cycle, clear acc/cnt, return to ACC.
REQ-027 Flush with cnt = 0 SHALL emit no word; flush_done pulses the cycle after flush.

Reset
REQ-028 rst_n low SHALL immediately force: state ACC, acc 0, cnt 0, out_valid 0, out_last 0, out_bits 0, out_data 0, flush_done 0, in_ready 0 while asserted.
REQ-029 Reset mid-word or mid-flush SHALL discard pending bits; no word emitted after release until new input.
REQ-030 in_ready SHALL be 1 first cycle after rst_n release.

Configuration
REQ-031 Macro BIT_PACK_CTRL_STATS_EN SHALL, when defined, add output stat_words (32 bits): count of completed out handshakes, reset 0, wraps at 2^32.
REQ-032 Without BIT_PACK_CTRL_STATS_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Single code in_data=32'h00002222, in_len=1, then flush -> one word out_data=32'h00000000, out_bits=1, out_last=1, then flush_done pulse.
REQ-034 Four codes 8'hAA,8'hBB,8'hCC,8'hDD each in_len=8, out_ready=1 -> out_data=32'hDDCCBBAA, out_bits=32, out_valid one cycle after 4th accept.
REQ-035 Codes len 20 (20'hFFFFF) then len 20 (20'h00001) -> word 32'h000FFFFF... i.e. out_data=32'h001FFFFF, cnt=8 remaining; flush -> out_data=32'h00000000, out_bits=8, out_last=1.
REQ-036 out_ready held 0 for 5 cycles with out_valid high -> out_data stable, in_ready=0, no accepts; release -> single handshake.
REQ-037 Flush with cnt=0 -> no out_valid, flush_done high exactly one cycle later; rst_n pulsed low with cnt=12 -> out_valid 0, cnt 0, subsequent flush emits nothing.
REQ-038 With BIT_PACK_CTRL_STATS_EN, REQ-034 then REQ-033 sequences -> stat_words=2.

Source files
------------

// File: rtl/bit_pack_ctrl.sv
// bit_pack_ctrl: packs variable-length codes into DATA_WIDTH-bit words.
// The first accepted code lands in the LSBs of a word. A flush request
// drains any partial word, marks it with out_last, then pulses flush_done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  code handshake; in_data is LSB-aligned, in_len bits valid
//   flush                single-cycle request to drain the partial word
//   out_valid/out_ready  packed word handshake
//   out_data, out_bits   packed word and its number of valid bits
//   out_last             word is the final word of a flush
//   flush_done           one-cycle pulse when a flush has completed
//   stat_words           (only with BIT_PACK_CTRL_STATS_EN) completed out handshakes
//
// Optional feature macro: BIT_PACK_CTRL_STATS_EN
module bit_pack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [LEN_WIDTH:0]    out_bits,
  output logic                  flush_done
`ifdef BIT_PACK_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_words
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_FULL = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH:0]   CNT_FULL = (LEN_WIDTH+1)'(DATA_WIDTH);

  typedef enum logic [1:0] {ACC, FLUSH, DONE} stateT;

  stateT                   state;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] accHs;
  logic [2*DATA_WIDTH-1:0] accNext;
  logic [2*DATA_WIDTH-1:0] codeWide;
  logic [LEN_WIDTH:0]      cnt;
  logic [LEN_WIDTH:0]      cntHs;
  logic [LEN_WIDTH:0]      cntNext;
  logic [LEN_WIDTH-1:0]    lenSat;
  logic                    handshake;
  logic                    accept;

  // Lengths beyond the word width are clamped to a full word.
  function automatic logic [LEN_WIDTH-1:0] satLen(input logic [LEN_WIDTH-1:0] len);
    return (len > LEN_FULL) ? LEN_FULL : len;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] maskCode(input logic [DATA_WIDTH-1:0] code,
                                                     input logic [LEN_WIDTH-1:0]  len);
    logic [DATA_WIDTH-1:0] mask;
    if (len == LEN_FULL) mask = '1;
    else                 mask = (DATA_WIDTH'(1) << len) - DATA_WIDTH'(1);
    return code & mask;
  endfunction

  // in_ready needs cnt below one word, so accept and emit never coincide.
  assign in_ready = rst_n && (state == ACC) && (cnt < CNT_FULL) && !flush;

  always_comb begin
    handshake = out_valid && out_ready;
    accept    = in_valid && in_ready;
    lenSat    = satLen(in_len);
    codeWide  = {{DATA_WIDTH{1'b0}}, maskCode(in_data, lenSat)} << cnt;
    accHs     = acc;
    cntHs     = cnt;
    // The final partial word of a flush is cleared on the way to DONE,
    // so only full words shift the accumulator down.
    if (handshake && !out_last) begin
      accHs = acc >> DATA_WIDTH;
      cntHs = cnt - CNT_FULL;
    end
    accNext = accept ? (accHs | codeWide) : accHs;
    cntNext = accept ? (cntHs + {1'b0, lenSat}) : cntHs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bits   <= '0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        ACC: begin
          acc <= accNext;
          cnt <= cntNext;
          if (cntNext >= CNT_FULL) begin
            out_valid <= 1'b1;
            out_data  <= accNext[DATA_WIDTH-1:0];
            out_bits  <= CNT_FULL;
            out_last  <= 1'b0;
            if (flush) state <= FLUSH;
          end else if (flush && (cntNext != '0)) begin
            // Bits above cnt are always zero, so the low word is already padded.
            out_valid <= 1'b1;
            out_data  <= accNext[DATA_WIDTH-1:0];
            out_bits  <= cntNext;
            out_last  <= 1'b1;
            state     <= FLUSH;
          end else if (flush) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            flush_done <= 1'b1;
            state      <= DONE;
          end else begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          acc <= accNext;
          cnt <= cntNext;
          if (!out_valid || handshake) begin
            if ((out_valid && out_last) || (cntNext == '0)) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              acc        <= '0;
              cnt        <= '0;
              flush_done <= 1'b1;
              state      <= DONE;
            end else if (cntNext >= CNT_FULL) begin
              out_valid <= 1'b1;
              out_data  <= accNext[DATA_WIDTH-1:0];
              out_bits  <= CNT_FULL;
              out_last  <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_data  <= accNext[DATA_WIDTH-1:0];
              out_bits  <= cntNext;
              out_last  <= 1'b1;
            end
          end
        end
        DONE: begin
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

`ifdef BIT_PACK_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stat_words <= '0;
    else if (handshake) stat_words <= stat_words + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bit_pack_ctrl.sv
// Bench for bit_pack_ctrl: directed sequence plus a short random stream.
// A reference packer pushes expected words into a queue as codes are
// accepted; a negedge monitor pops and compares on each out handshake.
module tb_bit_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [6:0]  out_bits;
  logic        flush_done;
`ifdef BIT_PACK_CTRL_STATS_EN
  logic [31:0] stat_words;
`endif

  logic fixedReady;
  logic randReady;
  logic rndBit = 1'b1;
  assign out_ready = randReady ? rndBit : fixedReady;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [6:0]  bits;
    logic        last;
  } wordT;
  wordT sb[$];

  logic [63:0] mAcc;
  int          mCnt;
  int          mWords;

  bit_pack_ctrl #(.DATA_WIDTH(32), .LEN_WIDTH(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_bits   (out_bits),
    .flush_done (flush_done)
`ifdef BIT_PACK_CTRL_STATS_EN
    ,
    .stat_words (stat_words)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rndBit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [6:0] b, input logic l);
    wordT w;
    w.data = d;
    w.bits = b;
    w.last = l;
    sb.push_back(w);
    mWords++;
  endtask

  task automatic modelAdd(input logic [31:0] d, input logic [5:0] l);
    int          ls;
    logic [31:0] m;
    ls = (int'(l) > 32) ? 32 : int'(l);
    m  = (ls == 0) ? 32'd0 : (d & (32'hFFFF_FFFF >> (32 - ls)));
    mAcc = mAcc | (64'(m) << mCnt);
    mCnt += ls;
    if (mCnt >= 32) begin
      push(mAcc[31:0], 7'd32, 1'b0);
      mAcc = mAcc >> 32;
      mCnt -= 32;
    end
  endtask

  task automatic modelFlush();
    if (mCnt > 0) push(mAcc[31:0], 7'(mCnt), 1'b1);
    mAcc = '0;
    mCnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCode(input logic [31:0] d, input logic [5:0] l);
    int w;
    bit done;
    w    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    while (!done && w < 50) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
      w++;
    end
    in_valid = 1'b0;
    check("acceptSeen", 64'(done), 64'd1);
    if (done) modelAdd(d, l);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    modelFlush();
  endtask

  task automatic waitFlushDone(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (flush_done) seen = 1'b1;
    end
    check("flushDoneSeen", 64'(seen), 64'd1);
    @(negedge clk);
    check("flushDoneOneCycle", 64'(flush_done), 64'd0);
    check("readyAfterDone", 64'(in_ready), 64'd1);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpectedWord", 64'(out_valid), 64'd0);
      end else begin
        wordT e;
        e = sb.pop_front();
        check("wordData", 64'(out_data), 64'(e.data));
        check("wordBits", 64'(out_bits), 64'(e.bits));
        check("wordLast", 64'(out_last), 64'(e.last));
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; flush = 1'b0;
    fixedReady = 1'b1; randReady = 1'b0;
    mAcc = '0; mCnt = 0; mWords = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rstInReady",   64'(in_ready),   64'd0);
    check("rstOutValid",  64'(out_valid),  64'd0);
    check("rstOutData",   64'(out_data),   64'd0);
    check("rstOutBits",   64'(out_bits),   64'd0);
    check("rstOutLast",   64'(out_last),   64'd0);
    check("rstFlushDone", 64'(flush_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("readyAfterRelease", 64'(in_ready), 64'd1);
    tick();

    // four bytes fill one word
    sendCode(32'hAA, 6'd8);
    sendCode(32'hBB, 6'd8);
    sendCode(32'hCC, 6'd8);
    check("noWordBefore4th", 64'(out_valid), 64'd0);
    sendCode(32'hDD, 6'd8);
    check("validAfter4th", 64'(out_valid), 64'd1);
    check("data4Bytes",    64'(out_data),  64'h0000_0000_DDCC_BBAA);
    check("bits4Bytes",    64'(out_bits),  64'd32);
    tick();
    check("validDropsAfterHs", 64'(out_valid), 64'd0);

    // single one-bit code then flush
    sendCode(32'h0000_2222, 6'd1);
    doFlush();
    check("partial1Valid", 64'(out_valid), 64'd1);
    check("partial1Data",  64'(out_data),  64'd0);
    check("partial1Bits",  64'(out_bits),  64'd1);
    check("partial1Last",  64'(out_last),  64'd1);
    waitFlushDone(cyc);
    check("flushDoneAfterPartial", 64'(cyc), 64'd2);
`ifdef BIT_PACK_CTRL_STATS_EN
    check("statWordsTwo", 64'(stat_words), 64'd2);
`endif

    // two 20-bit codes straddle a word boundary; upper in_data bits ignored
    sendCode(32'hFFFF_FFFF, 6'd20);
    sendCode(32'hFFF0_0001, 6'd20);
    check("straddleData", 64'(out_data), 64'h0000_0000_001F_FFFF);
    check("straddleBits", 64'(out_bits), 64'd32);
    doFlush();
    check("partial8Data", 64'(out_data), 64'd0);
    check("partial8Bits", 64'(out_bits), 64'd8);
    check("partial8Last", 64'(out_last), 64'd1);
    waitFlushDone(cyc);
    check("flushDoneAfter8", 64'(cyc), 64'd2);

    // oversize length clamps to a full word; zero length changes nothing
    sendCode(32'h1234_5678, 6'd40);
    check("satValid", 64'(out_valid), 64'd1);
    check("satData",  64'(out_data),  64'h0000_0000_1234_5678);
    tick();
    sendCode(32'hFFFF_FFFF, 6'd0);
    sendCode(32'h0000_0005, 6'd3);
    doFlush();
    check("len0Bits", 64'(out_bits), 64'd3);
    check("len0Data", 64'(out_data), 64'd5);
    waitFlushDone(cyc);

    // backpressure: word held, no accepts while stalled
    fixedReady = 1'b0;
    sendCode(32'h11, 6'd8);
    sendCode(32'h22, 6'd8);
    sendCode(32'h33, 6'd8);
    sendCode(32'h44, 6'd8);
    in_valid = 1'b1; in_data = 32'hFF; in_len = 6'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stallValid", 64'(out_valid), 64'd1);
      check("stallData",  64'(out_data),  64'h0000_0000_4433_2211);
      check("stallReady", 64'(in_ready),  64'd0);
      tick();
    end
    in_valid = 1'b0;
    fixedReady = 1'b1;
    tick();
    check("singleHs", 64'(out_valid), 64'd0);

    // flush with nothing buffered
    doFlush();
    check("emptyFlushNoWord", 64'(out_valid), 64'd0);
    waitFlushDone(cyc);
    check("emptyFlushLatency", 64'(cyc), 64'd1);

    // reset with 12 bits buffered discards them
    sendCode(32'h0000_0ABC, 6'd12);
    rst_n = 1'b0;
    #1;
    check("midRstValid", 64'(out_valid), 64'd0);
    check("midRstReady", 64'(in_ready),  64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mAcc = '0; mCnt = 0; mWords = 0;
    @(negedge clk);
    check("postRstReady", 64'(in_ready),  64'd1);
    check("postRstValid", 64'(out_valid), 64'd0);
    tick();
    doFlush();
    check("postRstFlushNoWord", 64'(out_valid), 64'd0);
    waitFlushDone(cyc);
    check("postRstFlushLatency", 64'(cyc), 64'd1);

    // reset while a partial flush word is stalled
    fixedReady = 1'b0;
    sendCode(32'h0000_0007, 6'd5);
    doFlush();
    check("stalledPartial", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midFlushRstValid", 64'(out_valid), 64'd0);
    sb.delete();
    mAcc = '0; mCnt = 0; mWords = 0;
    tick();
    rst_n = 1'b1;
    fixedReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noWordAfterRst", 64'(out_valid), 64'd0);
    end
    tick();

    // random stream with random backpressure
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sendCode($urandom, 6'($urandom_range(0, 34)));
    end
    randReady = 1'b0;
    doFlush();
    waitFlushDone(cyc);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboardEmpty", 64'(sb.size()), 64'd0);
`ifdef BIT_PACK_CTRL_STATS_EN
    check("statWordsTotal", 64'(stat_words), 64'(mWords));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
